// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types for the counter sequencer: FSM state encoding and
// the configuration bundle with its reset defaults.
package counter_seq_ctrl_pkg;

    localparam int CNT_W = 4;
    localparam int PRS_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0] limit;
        logic [PRS_W-1:0] prescale;
        logic             periodic;
    } cfg_t;

    localparam logic [CNT_W-1:0] CFG_LIMIT_RST    = '1;
    localparam logic [PRS_W-1:0] CFG_PRESCALE_RST = '0;
    localparam logic             CFG_PERIODIC_RST = 1'b1;

    localparam cfg_t CFG_RST = '{
        limit:    CFG_LIMIT_RST,
        prescale: CFG_PRESCALE_RST,
        periodic: CFG_PERIODIC_RST
    };

endpackage

// File: rtl/counter_seq_ctrl_prescaler.sv
// Prescaler: emits a step strobe every (prescale+1) enabled cycles.
// Disabled cycles freeze the phase so a held run resumes exactly.
module counter_seq_ctrl_prescaler
    import counter_seq_ctrl_pkg::*;
#(
    parameter int PRE_W = PRS_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [PRE_W-1:0] prescale,
    output logic             step
);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == prescale) begin
                cnt_d = '0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Counter sequencer: start/stop/hold FSM, config handshake and counter.
// COUNTER_SEQ_CTRL_STATS_EN adds a saturating wrap_count output.
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_W,
    parameter int PRE_W = PRS_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [PRE_W-1:0] cfg_prescale,
    input  logic             cfg_periodic,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             holding,
    output logic             wrap_pulse,
    output logic             toggle,
`ifdef COUNTER_SEQ_CTRL_STATS_EN
    output logic [15:0]      wrap_count,
`endif
    output logic             done
);

    state_e           state_q, state_d;
    cfg_t             cfg_q, cfg_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             toggle_q, toggle_d;
    logic             wrap_q, wrap_d;

    logic idle_or_done;
    logic start_new;
    logic hold_abort;
    logic pre_en;
    logic pre_clr;
    logic step;
    logic wrap_evt;

    assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
    assign start_new    = idle_or_done && cmd_start && !cmd_stop;
    assign hold_abort   = (state_q == HOLD) && cmd_stop;
    assign pre_en       = (state_q == RUN) && !cmd_stop;
    assign pre_clr      = start_new || hold_abort;
    assign wrap_evt     = pre_en && step && (count_q == cfg_q.limit);

    counter_seq_ctrl_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .enable   (pre_en),
        .clear    (pre_clr),
        .prescale (cfg_q.prescale),
        .step     (step)
    );

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        count_d  = count_q;
        toggle_d = toggle_q;
        wrap_d   = 1'b0;
        if (cfg_valid && idle_or_done) begin
            cfg_d = '{
                limit:    cfg_limit,
                prescale: cfg_prescale,
                periodic: cfg_periodic
            };
        end
        unique case (state_q)
            IDLE, DONE: begin
                // stop wins over start; from DONE it returns to IDLE
                if (cmd_stop) begin
                    state_d = IDLE;
                end else if (cmd_start) begin
                    state_d = RUN;
                    count_d = '0;
                end
            end
            RUN: begin
                if (cmd_stop) begin
                    state_d = HOLD;
                end else if (wrap_evt) begin
                    count_d  = '0;
                    wrap_d   = 1'b1;
                    toggle_d = ~toggle_q;
                    if (!cfg_q.periodic) begin
                        state_d = DONE;
                    end
                end else if (step) begin
                    count_d = count_q + 1'b1;
                end
            end
            HOLD: begin
                if (cmd_stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (cmd_start) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cfg_q    <= CFG_RST;
            count_q  <= '0;
            toggle_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            count_q  <= count_d;
            toggle_q <= toggle_d;
            wrap_q   <= wrap_d;
        end
    end

    assign cfg_ready  = idle_or_done;
    assign count      = count_q;
    assign busy       = (state_q == RUN);
    assign holding    = (state_q == HOLD);
    assign done       = (state_q == DONE);
    assign wrap_pulse = wrap_q;
    assign toggle     = toggle_q;

`ifdef COUNTER_SEQ_CTRL_STATS_EN
    logic [15:0] wcnt_q, wcnt_d;

    always_comb begin
        wcnt_d = wcnt_q;
        if (start_new) begin
            wcnt_d = '0;
        end else if (wrap_evt && (wcnt_q != 16'hFFFF)) begin
            wcnt_d = wcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign wrap_count = wcnt_q;
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed self-checking bench for counter_seq_ctrl.
// Define COUNTER_SEQ_CTRL_STATS_EN to also exercise wrap_count.
module tb_counter_seq_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_limit = '0;
    logic [7:0] cfg_prescale = '0;
    logic       cfg_periodic = 1'b0;
    logic       cmd_start = 1'b0;
    logic       cmd_stop = 1'b0;
    logic [3:0] count;
    logic       busy;
    logic       holding;
    logic       wrap_pulse;
    logic       toggle;
    logic       done;
`ifdef COUNTER_SEQ_CTRL_STATS_EN
    logic [15:0] wrap_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    counter_seq_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_limit    (cfg_limit),
        .cfg_prescale (cfg_prescale),
        .cfg_periodic (cfg_periodic),
        .cmd_start    (cmd_start),
        .cmd_stop     (cmd_stop),
        .count        (count),
        .busy         (busy),
        .holding      (holding),
        .wrap_pulse   (wrap_pulse),
        .toggle       (toggle),
`ifdef COUNTER_SEQ_CTRL_STATS_EN
        .wrap_count   (wrap_count),
`endif
        .done         (done)
    );

    // status vector: {count, busy, holding, done, cfg_ready, toggle, wrap}
    function automatic logic [9:0] st();
        return {count, busy, holding, done, cfg_ready, toggle, wrap_pulse};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        cfg_valid = 1'b0;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        reset     = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic cfg_start(input logic [3:0] lim, input logic [7:0] pre,
                             input logic per);
        cfg_limit    = lim;
        cfg_prescale = pre;
        cfg_periodic = per;
        cfg_valid    = 1'b1;
        cmd_start    = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        cmd_start = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1;
        tick(1);
        cmd_stop = 1'b0;
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1;
        tick(1);
        cmd_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] want;
        apply_reset();
        want = {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (st() !== want) begin
            n_fail++;
            $display("FAIL reset_defaults: got %b want %b", st(), want);
        end
        // default config: limit 15, prescale 0, periodic
        pulse_start();
        tick(15);
        n_checks++;
        if (count !== 4'd15) begin
            n_fail++;
            $display("FAIL default_limit: count %0d want 15", count);
        end
        tick(1);
        want = {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        n_checks++;
        if (st() !== want) begin
            n_fail++;
            $display("FAIL default_wrap: got %b want %b", st(), want);
        end
        tick(5);
        n_checks++;
        if (count !== 4'd5) begin
            n_fail++;
            $display("FAIL pre_reset_count: count %0d want 5", count);
        end
        #2;
        reset = 1'b1;
        #1;
        want = {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (st() !== want) begin
            n_fail++;
            $display("FAIL async_reset: got %b want %b", st(), want);
        end
        tick(1);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_periodic();
        logic [3:0] ec [9] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1,
                               4'd2, 4'd3, 4'd0, 4'd1};
        logic       ew [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        logic       et [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
        apply_reset();
        cfg_start(4'd3, 8'd0, 1'b1);
        n_checks++;
        if (count !== 4'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL periodic_start: count %0d busy %b want 0 1",
                     count, busy);
        end
        for (int i = 0; i < 9; i++) begin
            tick(1);
            n_checks++;
            if ({count, wrap_pulse, toggle} !== {ec[i], ew[i], et[i]}) begin
                n_fail++;
                $display("FAIL periodic_%0d: c/w/t %0d %b %b want %0d %b %b",
                         i, count, wrap_pulse, toggle, ec[i], ew[i], et[i]);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [3:0] ec [6] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0};
        logic [9:0] want;
        apply_reset();
        cfg_start(4'd2, 8'd1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            n_checks++;
            if (count !== ec[i]) begin
                n_fail++;
                $display("FAIL oneshot_%0d: count %0d want %0d",
                         i, count, ec[i]);
            end
        end
        want = {4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        n_checks++;
        if (st() !== want) begin
            n_fail++;
            $display("FAIL oneshot_done: got %b want %b", st(), want);
        end
        tick(2);
        want = {4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (st() !== want) begin
            n_fail++;
            $display("FAIL oneshot_stay: got %b want %b", st(), want);
        end
    endtask

    task automatic test_hold();
        logic [9:0] want;
        apply_reset();
        cfg_start(4'd7, 8'd2, 1'b1);
        tick(7);
        n_checks++;
        if (count !== 4'd2) begin
            n_fail++;
            $display("FAIL hold_pre: count %0d want 2", count);
        end
        pulse_stop();
        for (int i = 0; i < 10; i++) begin
            want = {4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            n_checks++;
            if (st() !== want) begin
                n_fail++;
                $display("FAIL hold_%0d: got %b want %b", i, st(), want);
            end
            tick(1);
        end
        // prescaler was frozen at phase 1 of 3
        pulse_start();
        tick(1);
        n_checks++;
        if (count !== 4'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_phase: count %0d busy %b want 2 1",
                     count, busy);
        end
        tick(1);
        n_checks++;
        if (count !== 4'd3) begin
            n_fail++;
            $display("FAIL resume_step: count %0d want 3", count);
        end
        pulse_stop();
        pulse_stop();
        want = {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (st() !== want) begin
            n_fail++;
            $display("FAIL hold_abort: got %b want %b", st(), want);
        end
    endtask

    task automatic test_collisions();
        logic [3:0] ec [4] = '{4'd1, 4'd0, 4'd1, 4'd0};
        logic       ew [4] = '{0, 1, 0, 1};
        logic [9:0] want;
        apply_reset();
        cmd_start = 1'b1;
        cmd_stop  = 1'b1;
        tick(1);
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        tick(1);
        want = {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (st() !== want) begin
            n_fail++;
            $display("FAIL start_stop_idle: got %b want %b", st(), want);
        end
        cfg_start(4'd0, 8'd0, 1'b0);
        tick(1);
        n_checks++;
        if (done !== 1'b1 || wrap_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL limit0_oneshot: done %b wrap %b want 1 1",
                     done, wrap_pulse);
        end
        cfg_start(4'd1, 8'd0, 1'b1);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL cfg_in_done: busy %b done %b count %0d",
                     busy, done, count);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_checks++;
            if ({count, wrap_pulse} !== {ec[i], ew[i]}) begin
                n_fail++;
                $display("FAIL limit1_%0d: c/w %0d %b want %0d %b",
                         i, count, wrap_pulse, ec[i], ew[i]);
            end
        end
        cfg_limit = 4'd3;
        cfg_valid = 1'b1;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_ready_run: got %b want 0", cfg_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_checks++;
            if (count !== ec[i]) begin
                n_fail++;
                $display("FAIL cfg_ignored_%0d: count %0d want %0d",
                         i, count, ec[i]);
            end
        end
        cfg_valid = 1'b0;
    endtask

`ifdef COUNTER_SEQ_CTRL_STATS_EN
    task automatic test_stats();
        apply_reset();
        cfg_start(4'd0, 8'd0, 1'b1);
        n_checks++;
        if (wrap_count !== 16'd0) begin
            n_fail++;
            $display("FAIL stats_start: got %0d want 0", wrap_count);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1);
            n_checks++;
            if (wrap_pulse !== 1'b1) begin
                n_fail++;
                $display("FAIL stats_pulse_%0d: got %b want 1",
                         i, wrap_pulse);
            end
        end
        n_checks++;
        if (wrap_count !== 16'd20) begin
            n_fail++;
            $display("FAIL stats_20: got %0d want 20", wrap_count);
        end
        pulse_stop();
        pulse_start();
        n_checks++;
        if (wrap_count !== 16'd20) begin
            n_fail++;
            $display("FAIL stats_resume: got %0d want 20", wrap_count);
        end
        tick(1);
        n_checks++;
        if (wrap_count !== 16'd21) begin
            n_fail++;
            $display("FAIL stats_21: got %0d want 21", wrap_count);
        end
        pulse_stop();
        pulse_stop();
        pulse_start();
        n_checks++;
        if (wrap_count !== 16'd0) begin
            n_fail++;
            $display("FAIL stats_restart: got %0d want 0", wrap_count);
        end
        tick(65540);
        n_checks++;
        if (wrap_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stats_sat: got %h want ffff", wrap_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_hold();
        test_collisions();
`ifdef COUNTER_SEQ_CTRL_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Controller that sequences a free-running-style WIDTH-bit counter datapath, with a paired toggle register.
- Adds a programmable terminal value, a prescaler, and one-shot or periodic modes.
- Provides a start/stop/hold command interface and a valid/ready configuration handshake.
- Sits between a host/test sequencer and the counter datapath. It drives count, a wrap pulse and the toggle state.

Parameters:
- WIDTH, 4, counter width in bits.
- PRE_W, 8, prescaler width in bits; a step occurs every (cfg_prescale+1) cycles.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted; high iff state is IDLE or DONE.
- cfg_limit  in  WIDTH  terminal count value, inclusive.
- cfg_prescale  in  PRE_W  cycles per step, minus 1.
- cfg_periodic  in  1  1 = periodic, 0 = one-shot.
- cmd_start  in  1  start or resume pulse.
- cmd_stop  in  1  hold or abort pulse.
- count  out  WIDTH  current counter value.
- busy  out  1  high while state is RUN.
- holding  out  1  high while state is HOLD.
- wrap_pulse  out  1  single-cycle pulse on the step that wraps limit->0.
- toggle  out  1  inverts on every wrap.
- done  out  1  high while state is DONE.

Behaviour:
- Reset (async, any time, including mid-run):
  - state=IDLE, count=0, prescaler=0, toggle=0, wrap_pulse=0.
  - Config registers: limit=all-ones, prescale=0, periodic=1.
  - Outputs: busy=0, holding=0, done=0, cfg_ready=1.
- Configuration:
  - Accepted on an edge where cfg_valid && cfg_ready; registers latched at that edge.
  - Not accepted in RUN or HOLD; cfg_valid is ignored and the sender must hold it.
- States: IDLE, RUN, HOLD, DONE.
- IDLE/DONE + cmd_start: -> RUN; count<=0, prescaler<=0, done<=0.
  - If a config is accepted in the same cycle, the run uses the new config.
- RUN, each edge:
  - If prescaler == prescale_reg: prescaler<=0 and a step occurs. Otherwise prescaler+1.
  - Step with count != limit: count+1.
  - Step with count == limit: count<=0, wrap_pulse=1 for the following cycle, toggle inverts.
  - After the wrap step: periodic stays in RUN; one-shot -> DONE.
  - cmd_start in RUN is ignored.
- RUN + cmd_stop: -> HOLD. count and prescaler freeze. A step due on that edge is suppressed.
- HOLD + cmd_start: -> RUN, resuming from the frozen count and prescaler.
- HOLD + cmd_stop: -> IDLE with count<=0. Toggle is kept.
- DONE + cmd_stop: -> IDLE; count is kept.
- IDLE + cmd_stop: no effect.
- cmd_start and cmd_stop in the same cycle: stop wins.
- Latency with prescale=0: start at edge t; count=1 after edge t+1; a step on every edge thereafter.
- limit=0: every step wraps; wrap_pulse stays high on consecutive cycles when prescale=0.
- Arithmetic is unsigned, modulo 2^WIDTH. The prescaler compare is equality only.

Optional Feature:
- Macro: COUNTER_SEQ_CTRL_STATS_EN.
- Defined: adds output port wrap_count [15:0].
  - Counts wraps, saturating at 16'hFFFF.
  - Cleared to 0 on reset and on every start from IDLE/DONE.
  - Not cleared on resume from HOLD.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package counter_seq_ctrl_pkg:
  - state_e enum (IDLE, RUN, HOLD, DONE).
  - cfg_t packed struct (limit, prescale, periodic).
  - Reset-default constants for cfg_t.
- One sub-module, counter_seq_ctrl_prescaler:
  - Inputs: enable, clear, prescale.
  - Output: step strobe.
  - Same clock/reset style as the parent.
- FSM, config registers and counter stay in the top module.

Test Plan:
- Reset defaults: assert reset mid-RUN with count=5 -> all outputs return to reset values immediately, asynchronously; count=0, toggle=0, cfg_ready=1.
- Periodic wrap: cfg limit=3, prescale=0, periodic=1; start -> count 1,2,3,0,1… on consecutive cycles; wrap_pulse high exactly on the cycle count=0; toggle flips at each wrap.
- One-shot with prescale: limit=2, prescale=1, periodic=0; start -> count steps every 2 cycles 0,1,2,0; then done=1, busy=0, count holds 0; cfg_ready=1.
- Hold/resume: stop at count=2 (limit=7, prescale=2) -> holding=1 and count stays 2 for 10 cycles; start -> resume with the remaining prescale phase intact; second stop from HOLD -> IDLE, count=0.
- Collisions: start+stop same cycle in IDLE -> stays IDLE. cfg_valid+start in DONE with limit=1 -> run wraps at 1. cfg_valid during RUN -> cfg_ready=0, config unchanged.
- Stats (macro defined): limit=0, prescale=0, periodic, 20 cycles -> wrap_count=20; restart -> 0. Force the counter near saturation -> it saturates at 16'hFFFF.
